// File: rtl/timer_core_if.sv
// Control and status bundle for timer_core: level inputs from the host,
// registered counter, capture and alarm results back to the host.
interface timer_core_if;
  logic        start_in;
  logic        capture_in;
  logic        rst_capture_in;
  logic        alarm_en_in;
  logic [31:0] alarm_in;
  logic [31:0] captured_out;
  logic [31:0] counter_out;
  logic        alarm_out;

  modport master (
    output start_in,
    output capture_in,
    output rst_capture_in,
    output alarm_en_in,
    output alarm_in,
    input  captured_out,
    input  counter_out,
    input  alarm_out
  );

  modport slave (
    input  start_in,
    input  capture_in,
    input  rst_capture_in,
    input  alarm_en_in,
    input  alarm_in,
    output captured_out,
    output counter_out,
    output alarm_out
  );
endinterface

// File: rtl/timer_core.sv
// Free-running 32-bit timer with an edge-triggered start, a capture register
// and a sticky alarm that compares the running count against a programmable value.
module timer_core (
  input  logic         clk_in,
  input  logic         rst_in,
  timer_core_if.slave  bus
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t      state_r;
  logic [31:0] counter_r;
  logic [31:0] captured_r;
  logic        alarm_r;
  logic        start_prev_r;
  logic        capture_prev_r;
  logic        rst_capture_prev_r;

  logic        start_pulse_s;
  logic        capture_pulse_s;
  logic        rst_capture_pulse_s;
  logic        alarm_match_s;

  // Rising-edge detection on the level inputs and the alarm compare term.
  always_comb begin
    start_pulse_s       = bus.start_in       & ~start_prev_r;
    capture_pulse_s     = bus.capture_in     & ~capture_prev_r;
    rst_capture_pulse_s = bus.rst_capture_in & ~rst_capture_prev_r;
    alarm_match_s       = (state_r == RUN) && (counter_r == bus.alarm_in);
  end

  // Timer state, capture register and sticky alarm.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_r            <= IDLE;
      counter_r          <= 32'd0;
      captured_r         <= 32'd0;
      alarm_r            <= 1'b0;
      start_prev_r       <= 1'b0;
      capture_prev_r     <= 1'b0;
      rst_capture_prev_r <= 1'b0;
    end else begin
      start_prev_r       <= bus.start_in;
      capture_prev_r     <= bus.capture_in;
      rst_capture_prev_r <= bus.rst_capture_in;

      // RUN is only left through reset; the counter wraps silently.
      case (state_r)
        IDLE: begin
          counter_r <= 32'd0;
          if (start_pulse_s) begin
            state_r <= RUN;
          end else begin
            state_r <= IDLE;
          end
        end
        RUN: begin
          state_r   <= RUN;
          counter_r <= counter_r + 32'd1;
        end
        default: begin
          state_r   <= IDLE;
          counter_r <= 32'd0;
        end
      endcase

      // Clear beats a coincident capture; capture uses the pre-edge count.
      if (rst_capture_pulse_s) begin
        captured_r <= 32'd0;
      end else if (capture_pulse_s && (state_r == RUN)) begin
        captured_r <= counter_r;
      end else begin
        captured_r <= captured_r;
      end

      if (!bus.alarm_en_in) begin
        alarm_r <= 1'b0;
      end else if (alarm_match_s) begin
        alarm_r <= 1'b1;
      end else begin
        alarm_r <= alarm_r;
      end
    end
  end

  assign bus.counter_out  = counter_r;
  assign bus.captured_out = captured_r;
  assign bus.alarm_out    = alarm_r;

endmodule

// File: tb/tb_timer_core.sv
// Directed bench for timer_core: start, capture, alarm, wrap and reset behaviour
// with hand-computed expected values.
module tb_timer_core;

  logic clk_in;
  logic rst_in;
  int   checks;
  int   errors;

  timer_core_if bus ();

  timer_core dut (
    .clk_in (clk_in),
    .rst_in (rst_in),
    .bus    (bus.slave)
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_in             = 1'b1;
    bus.start_in       = 1'b0;
    bus.capture_in     = 1'b0;
    bus.rst_capture_in = 1'b0;
    bus.alarm_en_in    = 1'b0;
    bus.alarm_in       = 32'd0;
    tick();
    tick();
    check("reset_counter",  bus.counter_out,  32'd0);
    check("reset_captured", bus.captured_out, 32'd0);
    check("reset_alarm",    {31'd0, bus.alarm_out}, 32'd1 - 32'd1);

    rst_in = 1'b0;
    tick();
    check("idle_counter", bus.counter_out, 32'd0);

    // Capture in IDLE is ignored; alarm never fires in IDLE even with alarm_in = 0.
    bus.capture_in  = 1'b1;
    bus.alarm_en_in = 1'b1;
    bus.alarm_in    = 32'd0;
    tick();
    bus.capture_in = 1'b0;
    tick();
    check("idle_capture", bus.captured_out, 32'd0);
    check("idle_alarm",   {31'd0, bus.alarm_out}, 32'd0);

    // Start at edge k together with a capture pulse (capture must be ignored).
    bus.alarm_in   = 32'd5;
    bus.start_in   = 1'b1;
    bus.capture_in = 1'b1;
    tick();
    bus.capture_in = 1'b0;
    check("start_counter0", bus.counter_out, 32'd0);
    check("start_capture_ignored", bus.captured_out, 32'd0);

    for (int i = 0; i < 5; i++) tick();
    check("counter_k5", bus.counter_out, 32'd5);
    check("alarm_k5",   {31'd0, bus.alarm_out}, 32'd0);
    tick();
    check("counter_k6", bus.counter_out, 32'd6);
    check("alarm_k6",   {31'd0, bus.alarm_out}, 32'd1);
    tick();
    check("counter_k7", bus.counter_out, 32'd7);

    // Capture rising at count 7, then held high.
    bus.capture_in = 1'b1;
    tick();
    check("capture_7", bus.captured_out, 32'd7);
    tick();
    check("capture_held", bus.captured_out, 32'd7);

    // Second start pulse causes no restart.
    bus.start_in = 1'b0;
    tick();
    check("counter_k10", bus.counter_out, 32'd10);
    bus.start_in = 1'b1;
    tick();
    check("no_restart", bus.counter_out, 32'd11);
    check("alarm_sticky", {31'd0, bus.alarm_out}, 32'd1);

    bus.rst_capture_in = 1'b1;
    tick();
    check("rst_capture", bus.captured_out, 32'd0);
    check("counter_after_rstcap", bus.counter_out, 32'd12);
    bus.rst_capture_in = 1'b0;
    bus.capture_in     = 1'b0;
    tick();
    bus.capture_in = 1'b1;
    tick();
    check("capture_13", bus.captured_out, 32'd13);
    bus.capture_in = 1'b0;
    tick();
    bus.capture_in     = 1'b1;
    bus.rst_capture_in = 1'b1;
    tick();
    check("clear_wins", bus.captured_out, 32'd0);
    bus.capture_in     = 1'b0;
    bus.rst_capture_in = 1'b0;

    // Changing alarm_in keeps the flag; dropping alarm_en clears it next edge.
    bus.alarm_in = 32'd99;
    tick();
    check("alarm_keep_after_change", {31'd0, bus.alarm_out}, 32'd1);
    bus.alarm_en_in = 1'b0;
    tick();
    check("alarm_cleared", {31'd0, bus.alarm_out}, 32'd0);
    check("counter_18", bus.counter_out, 32'd18);
    bus.alarm_en_in = 1'b1;
    bus.alarm_in    = 32'd19;
    tick();
    check("alarm_rearm_pre", {31'd0, bus.alarm_out}, 32'd0);
    tick();
    check("alarm_rearm", {31'd0, bus.alarm_out}, 32'd1);

    // Wrap around the 32-bit boundary.
    force dut.counter_r = 32'hFFFF_FFFE;
    #1;
    release dut.counter_r;
    tick();
    check("wrap_ffffffff", bus.counter_out, 32'hFFFF_FFFF);
    tick();
    check("wrap_zero", bus.counter_out, 32'h0000_0000);
    tick();
    check("wrap_one", bus.counter_out, 32'h0000_0001);
    check("alarm_after_wrap", {31'd0, bus.alarm_out}, 32'd1);

    // Reset mid-count with the alarm set.
    rst_in       = 1'b1;
    bus.start_in = 1'b0;
    tick();
    check("midrst_counter",  bus.counter_out,  32'd0);
    check("midrst_captured", bus.captured_out, 32'd0);
    check("midrst_alarm",    {31'd0, bus.alarm_out}, 32'd0);
    rst_in = 1'b0;
    tick();
    tick();
    check("after_rst_idle", bus.counter_out, 32'd0);

    // Start held high through reset release counts as a rising edge.
    rst_in       = 1'b1;
    bus.start_in = 1'b1;
    tick();
    rst_in = 1'b0;
    tick();
    check("held_start_0", bus.counter_out, 32'd0);
    tick();
    check("held_start_1", bus.counter_out, 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
